// File: rtl/regfile_pkg.sv
// Shared definitions for the register file bank.
//   DEFAULT_DATA_WIDTH / DEFAULT_NUM_REGS : default geometry of the bank
//   reg_addr_t : widest register index the bank supports (up to 64 entries)
//   in_range   : true when an index addresses an implemented register
package regfile_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_NUM_REGS   = 16;
   localparam int MAX_ADDR_WIDTH     = 6;

   typedef logic [MAX_ADDR_WIDTH-1:0] reg_addr_t;

   function automatic logic in_range(input reg_addr_t addr, input int num_regs);
      return (int'({{(32-MAX_ADDR_WIDTH){1'b0}}, addr}) < num_regs);
   endfunction

endpackage

// File: rtl/register_file_bank_scoreboard.sv
// Busy scoreboard for the register file bank: one pending-result bit per
// register. A write clears the bit of its target; a reservation sets it,
// and a reservation wins over a write to the same index in the same cycle.
// busy_a / busy_b are combinational lookups of the current scoreboard state.
// Optional build macro: REG_ZERO_EN (index 0 can never become busy).
// Ports:
//   clock, clear              : rising-edge clock, async active-high reset
//   wr_en, wr_addr            : completing write (clears busy)
//   rsv_en, rsv_addr          : reservation (sets busy)
//   rd_addr_a, rd_addr_b      : lookup indices
//   busy_a, busy_b            : busy bit of each lookup index
//   busy_vec                  : full scoreboard state
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NUM_REGS   = DEFAULT_NUM_REGS,
   parameter int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  rsv_en,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic                  busy_a,
   output logic                  busy_b,
   output logic [NUM_REGS-1:0]   busy_vec
);

`ifdef REG_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_next;

   always_comb begin
      busy_next = busy_q;
      if (wr_en && in_range(reg_addr_t'(wr_addr), NUM_REGS))
         busy_next[wr_addr] = 1'b0;
      // Applied after the clear so a same-index reservation takes priority.
      if (rsv_en && in_range(reg_addr_t'(rsv_addr), NUM_REGS))
         busy_next[rsv_addr] = 1'b1;
      if (ZERO_EN)
         busy_next[0] = 1'b0;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         busy_q <= '0;
      else
         busy_q <= busy_next;
   end

   always_comb begin
      busy_a = 1'b0;
      busy_b = 1'b0;
      if (in_range(reg_addr_t'(rd_addr_a), NUM_REGS))
         busy_a = busy_q[rd_addr_a];
      if (in_range(reg_addr_t'(rd_addr_b), NUM_REGS))
         busy_b = busy_q[rd_addr_b];
   end

   assign busy_vec = busy_q;

endmodule

// File: rtl/register_file_bank.sv
// Parametrised register bank: NUM_REGS registers of DATA_WIDTH bits, one
// write port, two registered read ports sharing one read strobe, and
// write-to-read bypass so a read in the same cycle as a write to the same
// index returns the new data. A busy scoreboard tracks pending results.
// Optional build macro: REG_ZERO_EN (register 0 hardwired to zero).
// Ports:
//   clock, clear              : rising-edge clock, async active-high reset
//   wr_en, wr_addr, wr_data   : write port
//   rd_en                     : read strobe for both ports
//   rd_addr_a, rd_addr_b      : read indices
//   rd_data_a, rd_data_b      : registered read data (1-cycle latency)
//   rsv_en, rsv_addr          : mark a register as pending
//   busy_a, busy_b            : busy bit of rd_addr_a / rd_addr_b
//   busy_vec                  : full scoreboard state
module register_file_bank
   import regfile_pkg::*;
#(
   parameter int          DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int          NUM_REGS   = DEFAULT_NUM_REGS,
   parameter int          ADDR_WIDTH = $clog2(NUM_REGS),
   parameter logic [31:0] INIT       = 32'h0
) (
   input  logic                  clock,
   input  logic                  clear,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr_a,
   input  logic [ADDR_WIDTH-1:0] rd_addr_b,
   output logic [DATA_WIDTH-1:0] rd_data_a,
   output logic [DATA_WIDTH-1:0] rd_data_b,
   input  logic                  rsv_en,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   output logic                  busy_a,
   output logic                  busy_b,
   output logic [NUM_REGS-1:0]   busy_vec
);

`ifdef REG_ZERO_EN
   localparam bit ZERO_EN = 1'b1;
`else
   localparam bit ZERO_EN = 1'b0;
`endif

   localparam logic [DATA_WIDTH-1:0] INIT_VAL = DATA_WIDTH'(INIT);

   logic [DATA_WIDTH-1:0] mem [NUM_REGS];
   logic                  wr_ok;
   logic [DATA_WIDTH-1:0] next_a;
   logic [DATA_WIDTH-1:0] next_b;

   assign wr_ok = wr_en && in_range(reg_addr_t'(wr_addr), NUM_REGS)
                  && !(ZERO_EN && (wr_addr == '0));

   // With REG_ZERO_EN, entry 0 resets to zero and is never written, so it
   // reduces to a constant and no storage remains for it.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         for (int i = 0; i < NUM_REGS; i++)
            mem[i] <= (ZERO_EN && (i == 0)) ? '0 : INIT_VAL;
      end else if (wr_ok) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      next_a = '0;
      next_b = '0;
      if (in_range(reg_addr_t'(rd_addr_a), NUM_REGS) && !(ZERO_EN && (rd_addr_a == '0))) begin
         if (wr_ok && (wr_addr == rd_addr_a))
            next_a = wr_data;
         else
            next_a = mem[rd_addr_a];
      end
      if (in_range(reg_addr_t'(rd_addr_b), NUM_REGS) && !(ZERO_EN && (rd_addr_b == '0))) begin
         if (wr_ok && (wr_addr == rd_addr_b))
            next_b = wr_data;
         else
            next_b = mem[rd_addr_b];
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         rd_data_a <= '0;
         rd_data_b <= '0;
      end else if (rd_en) begin
         rd_data_a <= next_a;
         rd_data_b <= next_b;
      end
   end

   regfile_scoreboard #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clock     (clock),
      .clear     (clear),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .busy_vec  (busy_vec)
   );

endmodule

// File: tb/tb_register_file_bank.sv
// Directed bench for register_file_bank with NUM_REGS=12 (non power of two)
// and INIT=32'hDEADBEEF. Expectations for register 0 follow REG_ZERO_EN.
module tb_register_file_bank;

`ifdef REG_ZERO_EN
   localparam bit ZERO = 1'b1;
`else
   localparam bit ZERO = 1'b0;
`endif

   localparam int NR = 12;
   localparam logic [31:0] IV      = 32'hDEAD_BEEF;
   localparam logic [31:0] R0_FF   = ZERO ? 32'h0 : 32'hFFFF_FFFF;
   localparam logic [31:0] R0_1234 = ZERO ? 32'h0 : 32'h0000_1234;
   localparam logic [11:0] BUSY_R0 = ZERO ? 12'h004 : 12'h005;

   logic        clock;
   logic        clear;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;
   logic [31:0] rd_data_a;
   logic [31:0] rd_data_b;
   logic        rsv_en;
   logic [3:0]  rsv_addr;
   logic        busy_a;
   logic        busy_b;
   logic [11:0] busy_vec;

   register_file_bank #(
      .DATA_WIDTH (32),
      .NUM_REGS   (NR),
      .ADDR_WIDTH (4),
      .INIT       (IV)
   ) dut (
      .clock     (clock),
      .clear     (clear),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_en     (rd_en),
      .rd_addr_a (rd_addr_a),
      .rd_addr_b (rd_addr_b),
      .rd_data_a (rd_data_a),
      .rd_data_b (rd_data_b),
      .rsv_en    (rsv_en),
      .rsv_addr  (rsv_addr),
      .busy_a    (busy_a),
      .busy_b    (busy_b),
      .busy_vec  (busy_vec)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic        wr_en;
      logic [3:0]  wr_addr;
      logic [31:0] wr_data;
      logic        rd_en;
      logic [3:0]  ra;
      logic [3:0]  rb;
      logic        rsv_en;
      logic [3:0]  rsv_addr;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [11:0] exp_busy;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en = 1'b0; rd_addr_a = '0; rd_addr_b = '0;
      rsv_en = 1'b0; rsv_addr = '0;
   endtask

   initial begin
      logic [11:0] prev_busy;
      logic        exp_ba;
      logic        exp_bb;

      //            wr  waddr wdata          rd   ra     rb     rsv  raddr  exp_a          exp_b          busy
      vecs[0]  = '{1'b1, 4'd5,  32'h1234_5678, 1'b0, 4'd0,  4'd0,  1'b0, 4'd0,  32'h0,         32'h0,         12'h000};
      vecs[1]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd5,  4'd1,  1'b0, 4'd0,  32'h1234_5678, IV,            12'h000};
      vecs[2]  = '{1'b0, 4'd0,  32'h0,         1'b0, 4'd2,  4'd2,  1'b0, 4'd0,  32'h1234_5678, IV,            12'h000};
      vecs[3]  = '{1'b1, 4'd3,  32'hA5A5_0001, 1'b1, 4'd3,  4'd3,  1'b0, 4'd0,  32'hA5A5_0001, 32'hA5A5_0001, 12'h000};
      vecs[4]  = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd7,  4'd5,  1'b1, 4'd7,  IV,            32'h1234_5678, 12'h080};
      vecs[5]  = '{1'b1, 4'd7,  32'h0000_0077, 1'b1, 4'd7,  4'd3,  1'b1, 4'd7,  32'h0000_0077, 32'hA5A5_0001, 12'h080};
      vecs[6]  = '{1'b1, 4'd7,  32'h0000_0078, 1'b0, 4'd7,  4'd3,  1'b0, 4'd0,  32'h0000_0077, 32'hA5A5_0001, 12'h000};
      vecs[7]  = '{1'b1, 4'd13, 32'h0000_0BAD, 1'b1, 4'd13, 4'd7,  1'b1, 4'd14, 32'h0,         32'h0000_0078, 12'h000};
      vecs[8]  = '{1'b1, 4'd11, 32'h0000_0B11, 1'b1, 4'd11, 4'd12, 1'b1, 4'd2,  32'h0000_0B11, 32'h0,         12'h004};
      vecs[9]  = '{1'b1, 4'd4,  32'h0000_0044, 1'b1, 4'd4,  4'd2,  1'b1, 4'd2,  32'h0000_0044, IV,            12'h004};
      vecs[10] = '{1'b1, 4'd0,  32'hFFFF_FFFF, 1'b0, 4'd2,  4'd4,  1'b1, 4'd0,  32'h0000_0044, IV,            BUSY_R0};
      vecs[11] = '{1'b0, 4'd0,  32'h0,         1'b1, 4'd0,  4'd0,  1'b0, 4'd0,  R0_FF,         R0_FF,         BUSY_R0};
      vecs[12] = '{1'b1, 4'd0,  32'h0000_1234, 1'b1, 4'd0,  4'd11, 1'b0, 4'd0,  R0_1234,       32'h0000_0B11, 12'h004};

      idle_inputs();
      clear = 1'b1;
      #3;
      check("reset rd_data_a", rd_data_a, 32'h0);
      check("reset rd_data_b", rd_data_b, 32'h0);
      check("reset busy_vec", {20'h0, busy_vec}, 32'h0);
      #9 clear = 1'b0;
      tick();

      prev_busy = 12'h000;
      for (int i = 0; i < NV; i++) begin
         wr_en     = vecs[i].wr_en;
         wr_addr   = vecs[i].wr_addr;
         wr_data   = vecs[i].wr_data;
         rd_en     = vecs[i].rd_en;
         rd_addr_a = vecs[i].ra;
         rd_addr_b = vecs[i].rb;
         rsv_en    = vecs[i].rsv_en;
         rsv_addr  = vecs[i].rsv_addr;
         #1;
         exp_ba = (int'(vecs[i].ra) < NR) ? prev_busy[vecs[i].ra] : 1'b0;
         exp_bb = (int'(vecs[i].rb) < NR) ? prev_busy[vecs[i].rb] : 1'b0;
         check($sformatf("v%0d busy_a", i), {31'h0, busy_a}, {31'h0, exp_ba});
         check($sformatf("v%0d busy_b", i), {31'h0, busy_b}, {31'h0, exp_bb});
         tick();
         check($sformatf("v%0d rd_data_a", i), rd_data_a, vecs[i].exp_a);
         check($sformatf("v%0d rd_data_b", i), rd_data_b, vecs[i].exp_b);
         check($sformatf("v%0d busy_vec", i), {20'h0, busy_vec}, {20'h0, vecs[i].exp_busy});
         prev_busy = vecs[i].exp_busy;
      end

      // Mid-cycle asynchronous reset with non-zero outputs and a pending
      // write/reservation on the inputs: outputs must clear without an edge.
      wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h0000_0066;
      rsv_en = 1'b1; rsv_addr = 4'd9; rd_en = 1'b1;
      #2 clear = 1'b1;
      #1;
      check("async clear rd_data_a", rd_data_a, 32'h0);
      check("async clear rd_data_b", rd_data_b, 32'h0);
      check("async clear busy_vec", {20'h0, busy_vec}, 32'h0);
      @(negedge clock);
      idle_inputs();
      clear = 1'b0;
      tick();
      check("post-reset hold rd_data_a", rd_data_a, 32'h0);

      for (int r = 0; r < NR; r += 2) begin
         rd_en = 1'b1;
         rd_addr_a = 4'(r);
         rd_addr_b = 4'(r + 1);
         tick();
         check($sformatf("init R%0d", r), rd_data_a, (ZERO && r == 0) ? 32'h0 : IV);
         check($sformatf("init R%0d", r + 1), rd_data_b, IV);
      end
      check("post-reset busy_vec", {20'h0, busy_vec}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/register_file_bank.md
Name: register_file_bank

Overview:
- Parametrised multi-entry register bank; successor to the single 32-bit bus register.
- Generalised in width and depth, with:
  - two registered read ports;
  - one write port;
  - write-to-read bypass;
  - a per-register busy scoreboard for pending results.
- Sits in the CPU datapath between the bus/ALU result path and the operand latches. Replaces discrete R0..R15 register instances.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 16, number of registers (2..64, need not be a power of two)
ADDR_WIDTH, $clog2(NUM_REGS), register address width
INIT, 32'h0, value loaded into every register on reset (truncated to DATA_WIDTH)

Ports:
clock  input  1  rising-edge clock
clear  input  1  asynchronous, active-high reset
wr_en  input  1  write strobe
wr_addr  input  ADDR_WIDTH  write register index
wr_data  input  DATA_WIDTH  write data
rd_en  input  1  read strobe, both ports
rd_addr_a  input  ADDR_WIDTH  port A index
rd_addr_b  input  ADDR_WIDTH  port B index
rd_data_a  output  DATA_WIDTH  port A registered data
rd_data_b  output  DATA_WIDTH  port B registered data
rsv_en  input  1  reserve strobe: mark rsv_addr as pending
rsv_addr  input  ADDR_WIDTH  register to reserve
busy_a  output  1  busy bit of rd_addr_a (combinational)
busy_b  output  1  busy bit of rd_addr_b (combinational)
busy_vec  output  NUM_REGS  full scoreboard state

Behaviour:
- Reset: clear=1 asynchronously forces:
  - all registers to INIT;
  - busy_vec to 0;
  - rd_data_a and rd_data_b to 0.
  - Reset takes effect mid-operation, regardless of any strobe.
  - Leaving reset: the first active edge is the first edge with clear=0.
- Write: at posedge with wr_en=1 and wr_addr<NUM_REGS, mem[wr_addr] <= wr_data. An out-of-range wr_addr is ignored.
- Read latency is 1 cycle. At posedge with rd_en=1, rd_data_x <= mem[rd_addr_x]. With rd_en=0, rd_data_x holds its value.
- An out-of-range rd_addr returns 0.
- Bypass: if wr_en=1, rd_en=1 and rd_addr_x==wr_addr (in range) in the same cycle, rd_data_x <= wr_data, never the stale value. Ports A and B bypass independently; both may hit.
- Scoreboard:
  - At posedge, wr_en clears busy[wr_addr]; rsv_en sets busy[rsv_addr].
  - Same address, same cycle: set wins, so busy=1 (the old op completes, a new op reserves).
  - Reserving an already-busy register: stays 1, no error.
  - A write to a non-busy register is legal; busy stays 0.
  - Out-of-range rsv_addr is ignored.
- busy_a/busy_b = busy_vec[rd_addr_x] before the edge; 0 for out-of-range addresses.
- No state machine beyond storage and scoreboard. All updates are single-edge.

Optional Feature:
REG_ZERO_EN
- Defined: register 0 is hardwired to zero.
  - Writes to index 0 are discarded.
  - Reads of index 0 return 0, including the bypass path.
  - rsv_en to index 0 is ignored; busy_vec[0] is constant 0.
  - Storage for index 0 is not synthesised.
- Undefined: register 0 is an ordinary register, identical to all other indices.

Decomposition:
- Shared package regfile_pkg holds:
  - the default DATA_WIDTH/NUM_REGS constants;
  - the reg_addr_t typedef;
  - a function in_range(addr, num_regs).
- One sub-module, regfile_scoreboard: the busy vector with its set/clear priority and the busy_a/busy_b lookup.
- Storage, read ports and bypass stay in the top module.

Test Plan:
- Reset values: assert clear async mid-cycle with INIT=32'hDEAD_BEEF after writes -> all regs read 32'hDEADBEEF, busy_vec=0, rd_data=0 immediately (before the next edge).
- Write then read: write R5=32'h1234_5678; next cycle rd_en, rd_addr_a=5 -> rd_data_a=32'h12345678 one edge later. rd_data holds while rd_en=0.
- Bypass: same cycle wr_en R3=32'hA5A5_0001, rd_en, rd_addr_a=3, rd_addr_b=3 -> both ports show 32'hA5A50001 after that edge.
- Scoreboard priority:
  - rsv R7 -> busy_vec[7]=1 and busy_a=1 with rd_addr_a=7.
  - Same cycle wr R7 + rsv R7 -> busy stays 1.
  - wr R7 alone -> busy 0.
- Out of range: NUM_REGS=12; write index 13 and reserve index 14 -> no change; read index 13 -> 0, busy_a=0.
- REG_ZERO_EN: write R0=32'hFFFF_FFFF, rsv R0 -> read R0=0 and busy_vec[0]=0. Without the macro: read R0=32'hFFFFFFFF and busy_vec[0]=1.
